mult8_dpath: RTL

Datapath responder for the nibble-serial 8x8 shift-add multiplier. It captures two 8-bit operands on `start` and forms one 4x4 partial product per step strobe, using the nibble selects and shift code issued by the multiplier controller. It accumulates the shifted partial products into a 16-bit sum and registers the final product when the controller raises `done`. It sits beside the controller and clock-enable sequencer: the controller drives the steps, and this block executes them.

---
 rtl/mult8_dpath.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mult8_dpath.sv
// Nibble-serial 8x8 shift-add multiplier datapath; executes controller steps.
// Optional step-order checker enabled by defining MULT8_SEQCHK_EN.
module mult8_dpath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    input  logic             step_vld,
    input  logic             input_sela,
    input  logic             input_selb,
    input  logic [1:0]       shift_sel,
    input  logic             done,
    output logic [15:0]      product,
    output logic             result_vld,
    output logic             busy,
    output logic             seq_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q;
    logic [15:0]      acc_q, acc_d;
    logic [15:0]      prod_q, prod_d;
    logic             vld_q, vld_d;

    logic [3:0]  nib_a, nib_b;
    logic [7:0]  partial;
    logic [15:0] shifted;
    logic [15:0] step_add;
    logic [15:0] acc_sum;
    logic        in_accum;
    logic        do_step;
    logic        do_done;

    assign nib_a = input_sela ? a_q[7:4] : a_q[3:0];
    assign nib_b = input_selb ? b_q[7:4] : b_q[3:0];

    always_comb begin
        partial = {4'h0, nib_a} * {4'h0, nib_b};
    end

    // Reserved shift code contributes nothing to the sum.
    always_comb begin
        shifted = 16'h0000;
        case (shift_sel)
            2'b00:   shifted = {8'h00, partial};
            2'b01:   shifted = {4'h0, partial, 4'h0};
            2'b10:   shifted = {partial, 8'h00};
            default: shifted = 16'h0000;
        endcase
    end

    assign step_add = step_vld ? shifted : 16'h0000;
    assign acc_sum  = acc_q + step_add;

    assign in_accum = (state_q == ACCUM);
    assign do_done  = in_accum & done & ~start;
    assign do_step  = in_accum & step_vld & ~done & ~start;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        vld_d   = 1'b0;
        unique case (1'b1)
            start: begin
                state_d = ACCUM;
                acc_d   = 16'h0000;
            end
            do_done: begin
                state_d = DONE;
                acc_d   = acc_sum;
                prod_d  = acc_sum;
                vld_d   = 1'b1;
            end
            do_step: begin
                acc_d = acc_sum;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 16'h0000;
            prod_q  <= 16'h0000;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (start) begin
            a_q <= dataa;
            b_q <= datab;
        end
    end

    assign product    = prod_q;
    assign result_vld = vld_q;
    assign busy       = in_accum;

`ifdef MULT8_SEQCHK_EN
    logic [2:0] cnt_q;
    logic       err_q;
    logic [3:0] code;
    logic [3:0] exp_code;
    logic [3:0] taken;
    logic       chk_step;
    logic       step_bad;
    logic       done_bad;

    assign code     = {input_sela, input_selb, shift_sel};
    assign chk_step = in_accum & step_vld & ~start;
    assign taken    = {1'b0, cnt_q} + {3'b000, step_vld};

    // Legal order: lo*lo<<0, lo*hi<<4, hi*lo<<4, hi*hi<<8.
    always_comb begin
        exp_code = 4'b0000;
        case (cnt_q)
            3'd0:    exp_code = 4'b0000;
            3'd1:    exp_code = 4'b0101;
            3'd2:    exp_code = 4'b1001;
            3'd3:    exp_code = 4'b1110;
            default: exp_code = 4'b0000;
        endcase
    end

    assign step_bad = (cnt_q > 3'd3) | (shift_sel == 2'b11) |
                      (code != exp_code);
    assign done_bad = (taken < 4'd4);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt_q <= 3'd0;
            err_q <= 1'b0;
        end else begin
            if (chk_step && cnt_q != 3'd7) begin
                cnt_q <= cnt_q + 3'd1;
            end
            if ((chk_step && step_bad) || (do_done && done_bad)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign seq_err = err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule
